// File: rtl/dispatcher_pkg.sv
// Types and widths for the per-core instruction dispatcher.
package dispatcher_pkg;
  import system_widths_pkg::*;

  localparam int DISP_INSTR_W = INSTR_W;
  localparam int DISP_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    WAIT  = 2'd3
  } disp_state_e;
endpackage

// File: rtl/system_widths_pkg.sv
// System-wide data widths shared by the core-array blocks.
package system_widths_pkg;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/instr_fifo.sv
// Single-core instruction FIFO: registered head, no bypass, synchronous flush.
module instr_fifo
  import dispatcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DISP_INSTR_W-1:0] din,
  output logic [DISP_INSTR_W-1:0] head,
  output logic                    empty,
  output logic                    full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DISP_INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    push_ok, pop_ok;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_W'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  // Stale storage is masked so an empty FIFO always presents zero.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/instr_dispatcher.sv
// Routes host instructions into per-core FIFOs, counts deliveries, and runs the drain handshake.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module instr_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              host_valid,
  output logic                              host_ready,
  input  logic [DISP_INSTR_W-1:0]           host_instr,
  input  logic [CID_W-1:0]                  host_core_id,
  output logic [NUM_CORES-1:0]              core_valid,
  output logic [NUM_CORES*DISP_INSTR_W-1:0] core_instr,
  input  logic [NUM_CORES-1:0]              core_ready,
  input  logic                              flush,
  input  logic                              drain_req,
  output logic                              drain_done,
  output logic [NUM_CORES-1:0]              fifo_full,
  output logic [NUM_CORES*DISP_CNT_W-1:0]   disp_count,
  output logic [1:0]                        dbg_state
);
  disp_state_e            state_q, state_d;
  logic [NUM_CORES-1:0]   empty_w, push_w, pop_w;
  logic [DISP_CNT_W-1:0]  cnt_q [NUM_CORES];
  logic [DISP_CNT_W-1:0]  cnt_d [NUM_CORES];
  logic                   sel_full, host_fire, quiesced;

  // An out-of-range core ID matches no FIFO: it reads as not full and the word is dropped.
  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (host_core_id == CID_W'(i)) sel_full = fifo_full[i];
    end
  end

  assign host_ready = (state_q == IDLE) && !sel_full;
  assign host_fire  = host_valid && host_ready;

  always_comb begin
    push_w = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (host_core_id == CID_W'(i)) push_w[i] = host_fire;
    end
  end

  // Flush suppresses the pop, so the delivery counter must not advance either.
  assign pop_w = core_valid & core_ready & {NUM_CORES{!flush}};

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (resetN),
      .push  (push_w[g]),
      .pop   (pop_w[g]),
      .flush (flush),
      .din   (host_instr),
      .head  (core_instr[g*DISP_INSTR_W +: DISP_INSTR_W]),
      .empty (empty_w[g]),
      .full  (fifo_full[g])
    );

    assign core_valid[g] = !empty_w[g];
    assign cnt_d[g]      = pop_w[g] ? cnt_q[g] + DISP_CNT_W'(1) : cnt_q[g];
    assign disp_count[g*DISP_CNT_W +: DISP_CNT_W] = cnt_q[g];

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) cnt_q[g] <= '0;
      else         cnt_q[g] <= cnt_d[g];
    end
  end

  assign quiesced = (&empty_w) && (&core_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req)    state_d = IDLE;
        else if (quiesced) state_d = DONE;
      end
      DONE:    state_d = WAIT;
      WAIT:    if (!drain_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign drain_done = (state_q == DONE);
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: per-core expected queues checked by a negedge monitor.
module tb_instr_dispatcher;
  localparam int NC = 4;

  logic          clk, resetN;
  logic          host_valid, host_ready;
  logic [31:0]   host_instr;
  logic [1:0]    host_core_id;
  logic [NC-1:0] core_valid, core_ready, fifo_full;
  logic [NC*32-1:0] core_instr;
  logic [NC*16-1:0] disp_count;
  logic          flush, drain_req, drain_done;
  logic [1:0]    dbg_state;

  logic [31:0] exp_q [NC][$];
  logic [15:0] exp_disp [NC];
  int checks = 0;
  int errors = 0;

  instr_dispatcher #(.NUM_CORES(NC), .FIFO_DEPTH(8)) dut (
    .clk(clk), .resetN(resetN), .host_valid(host_valid), .host_ready(host_ready),
    .host_instr(host_instr), .host_core_id(host_core_id), .core_valid(core_valid),
    .core_instr(core_instr), .core_ready(core_ready), .flush(flush),
    .drain_req(drain_req), .drain_done(drain_done), .fifo_full(fifo_full),
    .disp_count(disp_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: offer one word, wait (bounded) for acceptance
  task automatic push(input int c, input logic [31:0] d);
    int n;
    n = 0;
    host_valid   = 1'b1;
    host_core_id = 2'(c);
    host_instr   = d;
    @(negedge clk);
    while (!host_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!host_ready) begin
      errors++;
      $display("FAIL push_timeout: core %0d word %h never accepted", c, d);
    end else begin
      exp_q[c].push_back(d);
    end
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic clear_model(input logic clr_cnt);
    for (int i = 0; i < NC; i++) begin
      exp_q[i].delete();
      if (clr_cnt) exp_disp[i] = '0;
    end
  endtask

  // monitor: every handshake about to land pops the scoreboard
  always @(negedge clk) begin
    if (resetN && !flush) begin
      for (int i = 0; i < NC; i++) begin
        if (core_valid[i] && core_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: core %0d got %h expected none", i, core_instr[i*32 +: 32]);
          end else begin
            chk($sformatf("deliver_core%0d", i), 64'(core_instr[i*32 +: 32]), 64'(exp_q[i].pop_front()));
          end
          exp_disp[i] = exp_disp[i] + 16'd1;
        end
      end
    end
  end

  initial begin
    int hi_cycles;
    logic q3_empty_at_done;
    resetN = 1'b0; host_valid = 1'b0; host_instr = '0; host_core_id = '0;
    core_ready = '0; flush = 1'b0; drain_req = 1'b0;
    clear_model(1'b1);
    #12;
    chk("rst_core_valid", 64'(core_valid), 64'h0);
    chk("rst_fifo_full", 64'(fifo_full), 64'h0);
    chk("rst_disp_count", disp_count, 64'h0);
    chk("rst_core_instr", 64'(core_instr[63:0]), 64'h0);
    chk("rst_drain_done", 64'(drain_done), 64'h0);
    #10 resetN = 1'b1;
    cyc(1);
    chk("host_ready_after_reset", 64'(host_ready), 64'h1);

    // single word to core 2
    core_ready = 4'b0100;
    push(2, 32'h0000_1111);
    chk("c2_valid_next_cycle", 64'(core_valid), 64'b0100);
    chk("c2_instr", 64'(core_instr[64 +: 32]), 64'h0000_1111);
    cyc(1);
    chk("c2_disp_count", disp_count, {16'd0, 16'd1, 16'd0, 16'd0});
    chk("c2_drained", 64'(core_valid), 64'h0);

    // fill core 0, then drain it at one word per cycle
    core_ready = 4'b0000;
    for (int k = 0; k < 8; k++) push(0, 32'hA000_0000 + 32'(k));
    chk("c0_full", 64'(fifo_full), 64'b0001);
    host_core_id = 2'd0;
    #1 chk("host_ready_full_core", 64'(host_ready), 64'h0);
    host_core_id = 2'd1;
    #1 chk("host_ready_other_core", 64'(host_ready), 64'h1);
    core_ready = 4'b0001;
    cyc(8);
    chk("c0_all_delivered", 64'(disp_count[15:0]), 64'd8);
    chk("c0_empty_after_8", 64'(core_valid), 64'h0);

    // core 1: 3 entries, then 17 cycles of push+pop across the pointer wrap
    core_ready = 4'b0000;
    for (int k = 0; k < 3; k++) push(1, 32'hB000_0000 + 32'(k));
    core_ready = 4'b0010;
    for (int k = 3; k < 20; k++) push(1, 32'hB000_0000 + 32'(k));
    core_ready = 4'b0000;
    chk("c1_stream_count", 64'(disp_count[31:16]), 64'd17);
    chk("c1_not_full", 64'(fifo_full), 64'h0);
    core_ready = 4'b0010;
    cyc(2);
    chk("c1_occ3_still_valid", 64'(core_valid[1]), 64'h1);
    cyc(1);
    chk("c1_occ3_empty", 64'(core_valid[1]), 64'h0);
    chk("c1_total_count", 64'(disp_count[31:16]), 64'd20);

    // flush with 5 entries held, concurrent push and pop attempts
    core_ready = 4'b0000;
    for (int k = 0; k < 3; k++) push(0, 32'hC000_0000 + 32'(k));
    for (int k = 0; k < 2; k++) push(3, 32'hC300_0000 + 32'(k));
    chk("pre_flush_valid", 64'(core_valid), 64'b1001);
    flush = 1'b1; host_valid = 1'b1; host_core_id = 2'd2; host_instr = 32'hDEAD_BEEF;
    core_ready = 4'b1111;
    clear_model(1'b0);
    cyc(1);
    flush = 1'b0; host_valid = 1'b0;
    chk("flush_valid", 64'(core_valid), 64'h0);
    chk("flush_disp_count", disp_count, {16'd0, 16'd1, 16'd20, 16'd8});
    cyc(1);
    chk("flush_push_dropped", 64'(core_valid), 64'h0);

    // drain with 2 entries pending at core 3
    core_ready = 4'b0000;
    push(3, 32'hD300_0000);
    push(3, 32'hD300_0001);
    drain_req = 1'b1;
    cyc(1);
    host_core_id = 2'd1;
    #1 chk("drain_host_ready", 64'(host_ready), 64'h0);
    core_ready = 4'b1111;
    hi_cycles = 0;
    q3_empty_at_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drain_done) begin
        if (hi_cycles == 0) q3_empty_at_done = (exp_q[3].size() == 0);
        hi_cycles++;
      end
    end
    chk("drain_done_pulses", 64'(hi_cycles), 64'd1);
    chk("drain_done_after_pops", 64'(q3_empty_at_done), 64'h1);
    chk("drain_c3_count", 64'(disp_count[63:48]), 64'd2);
    chk("wait_host_ready", 64'(host_ready), 64'h0);
    @(posedge clk);
    #1 drain_req = 1'b0;
    cyc(1);
    chk("post_drain_host_ready", 64'(host_ready), 64'h1);

    // asynchronous reset mid-stream
    core_ready = 4'b0000;
    push(1, 32'hE100_0000);
    push(1, 32'hE100_0001);
    push(2, 32'hE200_0000);
    @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    chk("async_rst_valid", 64'(core_valid), 64'h0);
    chk("async_rst_disp", disp_count, 64'h0);
    chk("async_rst_instr", 64'(core_instr[95:32]), 64'h0);
    chk("async_rst_full", 64'(fifo_full), 64'h0);
    clear_model(1'b1);
    #10 resetN = 1'b1;
    cyc(1);
    core_ready = 4'b0001;
    push(0, 32'h5555_0000);
    cyc(1);
    chk("post_rst_count", 64'(disp_count[15:0]), 64'd1);

    cyc(2);
    chk("scoreboard_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
    chk("model_disp", disp_count, {exp_disp[3], exp_disp[2], exp_disp[1], exp_disp[0]});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
